// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset/lock sequencer with stretched system reset and debounced reset button
module pll_supervisor #(
    parameter int PLL_RST_CYCLES  = 32,
    parameter int LOCK_TIMEOUT    = 500000,
    parameter int HOLD_CYCLES     = 65536,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk50m,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       button_n,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic [3:0] retry_count,
    output logic       lock_lost
);
    localparam logic [19:0] P_LAST = 20'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] T_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] H_LAST = 20'(HOLD_CYCLES - 1);
    localparam logic [19:0] D_LAST = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_PLLRST, S_WAIT_LOCK, S_HOLD, S_RUN} state_t;

    state_t      state, state_nx;
    logic [19:0] cnt, cnt_nx, db_cnt;
    logic [1:0]  locked_sync, button_sync;
    logic        locked_s, button_s, button_db;
    logic        retry_inc, lost_set;

    assign locked_s = locked_sync[1];
    assign button_s = button_sync[1];

    // two-flop synchronisers for the asynchronous lock and button inputs
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            locked_sync <= 2'b00;
            button_sync <= 2'b11;
        end else begin
            locked_sync <= {locked_sync[0], pll_locked};
            button_sync <= {button_sync[0], button_n};
        end
    end

    // debouncer: adopt the synchronised button only after it has differed for the full window
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            button_db <= 1'b1;
            db_cnt    <= '0;
        end else if (button_s == button_db) begin
            db_cnt <= '0;
        end else if (db_cnt == D_LAST) begin
            button_db <= button_s;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 20'd1;
        end
    end

    // next state and shared counter; loss of lock is checked before the button everywhere
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 20'd1;
        retry_inc = 1'b0;
        lost_set  = 1'b0;
        case (state)
            S_PLLRST: begin
                if (cnt == P_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end else if (cnt == T_LAST) begin
                    state_nx  = S_PLLRST;
                    cnt_nx    = '0;
                    retry_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_nx = S_PLLRST;
                    cnt_nx   = '0;
                end else if (!button_db) begin
                    cnt_nx = '0;
                end else if (cnt == H_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end
            end
            S_RUN: begin
                cnt_nx = '0;
                if (!locked_s) begin
                    state_nx = S_PLLRST;
                    lost_set = 1'b1;
                end else if (!button_db) begin
                    state_nx = S_HOLD;
                end
            end
            default: begin
                state_nx = S_PLLRST;
                cnt_nx   = '0;
            end
        endcase
    end

    // state register with outputs decoded from the next state so they change with the transition
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_PLLRST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            retry_count <= 4'd0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pll_rst     <= (state_nx == S_PLLRST);
            sys_reset_n <= (state_nx == S_RUN);
            if (retry_inc && retry_count != 4'd15)
                retry_count <= retry_count + 4'd1;
            if (lost_set)
                lock_lost <= 1'b1;
        end
    end
endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequencer upstream of the DE0-CV system PLL, running on the 50 MHz board reference clock that also feeds the PLL.
- Holds the PLL in reset after power-on.
- Waits for lock, with a timeout and retry.
- Stretches a system reset until the PLL outputs (21.477 MHz / 85.909 MHz) are stable.
- Re-enters reset on loss of lock or on a debounced reset-button press.

`sys_reset_n` is resynchronised by each consuming clock domain.

## Interface
Parameters:
- PLL_RST_CYCLES, 32: cycles `pll_rst` is held high per attempt.
- LOCK_TIMEOUT, 500000: cycles waited for lock (10 ms) before retrying.
- HOLD_CYCLES, 65536: cycles `sys_reset_n` is held low after lock.
- DEBOUNCE_CYCLES, 250000: cycles `button_n` must be stable before the debounced value changes.
- All parameters lie in 1 .. 2^20-1. One shared 20-bit cycle counter serves the state machine; a separate 20-bit counter serves the debouncer.

Ports:
- clk50m  in  1  50 MHz board reference clock.
- reset_n  in  1  asynchronous, active-low power-on/board reset.
- pll_locked  in  1  PLL `locked` output, asynchronous to clk50m.
- button_n  in  1  reset push-button, active-low, asynchronous, bouncing.
- pll_rst  out  1  drives the PLL `rst` input, active-high.
- sys_reset_n  out  1  system reset, active-low.
- retry_count  out  4  number of lock timeouts; saturates at 15.
- lock_lost  out  1  sticky flag: lock was lost while in S_RUN.

## Operation
- All outputs are registered.
- While reset_n=0 (asynchronous), outputs are: pll_rst=1, sys_reset_n=0, retry_count=0, lock_lost=0. State is S_PLLRST, counters are 0.
- Synchronisers (2 flops each):
  - locked_s: reset value 0.
  - button_s: reset value 1.
- Debouncer:
  - button_db has reset value 1.
  - button_db takes button_s only after button_s has differed from button_db for DEBOUNCE_CYCLES consecutive cycles.
  - Any return of button_s to equal button_db clears the debounce counter.
- States:
  - S_PLLRST: pll_rst=1. After PLL_RST_CYCLES cycles in this state, go to S_WAIT_LOCK and clear the counter.
  - S_WAIT_LOCK: pll_rst=0.
    - If locked_s=1, go to S_HOLD.
    - Else, at counter = LOCK_TIMEOUT-1, go to S_PLLRST and increment retry_count (saturating).
    - If locked_s=1 on the timeout cycle, lock wins: go to S_HOLD, no retry.
  - S_HOLD: sys_reset_n=0.
    - If locked_s=0, go to S_PLLRST.
    - Else, while button_db=0, the counter is held at 0.
    - Else, after HOLD_CYCLES cycles, go to S_RUN.
  - S_RUN: sys_reset_n=1.
    - If locked_s=0, go to S_PLLRST and set lock_lost=1.
    - Else, if button_db=0, go to S_HOLD with the counter cleared.
- Loss of lock has priority over the button in every state.
- sys_reset_n=0 in all states other than S_RUN.
- retry_count and lock_lost are cleared only by reset_n.

## Timing
- Outputs change on the same clk50m edge as the state transition that causes them.
- Reset release: pll_rst stays high for exactly PLL_RST_CYCLES rising edges after the first edge with reset_n=1, then falls.
- Lock latency: pll_locked rising before edge e gives S_HOLD at edge e+2.
- sys_reset_n rises HOLD_CYCLES edges after entry into S_HOLD. Total from pll_locked rise to sys_reset_n rise: HOLD_CYCLES+2 edges.
- Lock-loss latency: pll_locked falling before edge e gives sys_reset_n=0 and pll_rst=1 at edge e+2.
- Button latency:
  - Press: DEBOUNCE_CYCLES+2 edges from the button_n fall (asynchronous input) to sys_reset_n=0.
  - Release: sys_reset_n rises HOLD_CYCLES edges after button_db returns to 1.
- Retry period with no lock: PLL_RST_CYCLES+LOCK_TIMEOUT cycles.
- reset_n assertion at any time (including mid-S_HOLD or mid-debounce) forces reset values immediately, without waiting for a clock edge.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLD_CYCLES=8, DEBOUNCE_CYCLES=5.
- Release reset_n; raise pll_locked 10 edges later -> pll_rst high exactly 4 edges; sys_reset_n rises 10 edges after pll_locked rises; retry_count=0.
- pll_locked held 0 -> pll_rst is a 4-cycle pulse every 24 cycles; retry_count reads 1, 2, … and saturates at 15 after the 15th timeout.
- In S_RUN, drop pll_locked for 1 cycle -> sys_reset_n=0 and pll_rst=1 two edges later; lock_lost=1; after relock, sys_reset_n=1 again after 4+…+10 edges; retry_count unchanged.
- In S_RUN, pulse button_n low for 3 cycles -> no change. Hold low 12 cycles -> sys_reset_n falls 7 edges after the fall and rises 8 edges after button_db returns to 1.
- Raise pll_locked on the exact timeout edge of S_WAIT_LOCK -> S_HOLD entered; retry_count not incremented.
- Assert reset_n mid-S_HOLD with button bouncing -> all outputs take reset values asynchronously; the full sequence replays on release.
